// File: rtl/tlk2711_tx_pattern_ctrl.sv
// TLK2711 test-mode transmit sequencer.
// On a start edge, emits a programmable number of pattern frames into the tx FIFO
// write port, drives the tx validation checker enable and reports progress/completion.
module tlk2711_tx_pattern_ctrl #(
   parameter int unsigned NORM_LAST  = 434,
   parameter int unsigned MODE3_LAST = 5375,
   parameter int unsigned GAP_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_soft_rst,
   input  logic             i_tx_start,
   input  logic [2:0]       i_tx_mode,
   input  logic [15:0]      i_frame_num,
   input  logic [GAP_W-1:0] i_gap_cycles,
   input  logic             i_stop,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [15:0]      o_data,
   output logic             o_last,
   output logic             o_busy,
   output logic             o_done,
   output logic [15:0]      o_frame_cnt,
   output logic             o_check_ena
);

   localparam int unsigned IDX_W = 13;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_GAP,
      S_DONE
   } state_t;

   state_t             state;
   state_t             state_d;

   logic               start_q;
   logic               start_p;
   logic [IDX_W-1:0]   last_q;
   logic [15:0]        frame_num_q;
   logic [GAP_W-1:0]   gap_q;
   logic [GAP_W-1:0]   gap_cnt;
   logic [IDX_W-1:0]   w_q;

   logic               accept_c;
   logic               word_last_c;
   logic               frame_end_c;
   logic               run_full_c;
   logic               gap_end_c;
   logic               new_frame_c;
   logic [15:0]        cnt_inc_c;
   logic [IDX_W-1:0]   w_inc_c;
   logic [7:0]         pat_byte_c;
   logic               valid_d;
   logic               busy_d;
   logic               done_d;

   // Handshake and frame-boundary decode shared by FSM and datapath.
   always_comb begin
      accept_c    = (state == S_SEND) & i_ready;
      word_last_c = (w_q == last_q);
      frame_end_c = accept_c & word_last_c;
      cnt_inc_c   = o_frame_cnt + 16'd1;
      run_full_c  = (frame_num_q != 16'd0) && (cnt_inc_c == frame_num_q);
      gap_end_c   = (GAP_W'(gap_cnt + GAP_W'(1)) == gap_q);
      w_inc_c     = IDX_W'(w_q + IDX_W'(1));
      // Both bytes follow the low byte, so 0x0001 -> 0x0303 -> ... -> 0xFFFF -> 0x0101.
      pat_byte_c  = 8'(o_data[7:0] + 8'd2);
   end

   // Next-state and next-output decode.
   always_comb begin
      state_d     = state;
      valid_d     = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      new_frame_c = 1'b0;
      case (state)
         S_IDLE: if (start_p) state_d = S_LOAD;
         S_LOAD: state_d = S_SEND;
         S_SEND: begin
            if (frame_end_c) begin
               if (run_full_c || i_stop)  state_d = S_DONE;
               else if (gap_q != '0)      state_d = S_GAP;
               else                       state_d = S_SEND;
            end
         end
         S_GAP: begin
            if (i_stop)         state_d = S_DONE;
            else if (gap_end_c) state_d = S_SEND;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      valid_d     = (state_d == S_SEND);
      busy_d      = (state_d == S_LOAD) || (state_d == S_SEND) || (state_d == S_GAP);
      done_d      = (state_d == S_DONE);
      new_frame_c = (state_d == S_SEND) && ((state != S_SEND) || frame_end_c);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          state <= S_IDLE;
      else if (i_soft_rst) state <= S_IDLE;
      else                 state <= state_d;
   end

   // Start edge detector, registered pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         start_p <= 1'b0;
      end else if (i_soft_rst) begin
         start_q <= 1'b0;
         start_p <= 1'b0;
      end else begin
         start_q <= i_tx_start;
         start_p <= i_tx_start & ~start_q;
      end
   end

   // Run configuration latched at the accepted start edge, plus frame counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q      <= '0;
         frame_num_q <= '0;
         gap_q       <= '0;
         o_frame_cnt <= '0;
      end else if (i_soft_rst) begin
         last_q      <= '0;
         frame_num_q <= '0;
         gap_q       <= '0;
         o_frame_cnt <= '0;
      end else if ((state == S_IDLE) && start_p) begin
         last_q      <= (i_tx_mode == 3'd3) ? IDX_W'(MODE3_LAST) : IDX_W'(NORM_LAST);
         frame_num_q <= i_frame_num;
         gap_q       <= i_gap_cycles;
         o_frame_cnt <= '0;
      end else if (frame_end_c) begin
         o_frame_cnt <= cnt_inc_c;
      end
   end

   // Inter-frame gap counter, counts cycles spent in GAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                gap_cnt <= '0;
      else if (i_soft_rst)       gap_cnt <= '0;
      else if (state == S_GAP)   gap_cnt <= GAP_W'(gap_cnt + GAP_W'(1));
      else                       gap_cnt <= '0;
   end

   // Word index and output word; holds while the FIFO stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q    <= '0;
         o_data <= '0;
         o_last <= 1'b0;
      end else if (i_soft_rst) begin
         w_q    <= '0;
         o_data <= '0;
         o_last <= 1'b0;
      end else if (new_frame_c) begin
         w_q    <= '0;
         o_data <= 16'h0001;
         o_last <= (last_q == '0);
      end else if (state_d != S_SEND) begin
         w_q    <= '0;
         o_data <= '0;
         o_last <= 1'b0;
      end else if (accept_c) begin
         w_q    <= w_inc_c;
         o_data <= (w_inc_c == last_q) ? o_frame_cnt : {pat_byte_c, pat_byte_c};
         o_last <= (w_inc_c == last_q);
      end
   end

   // Status outputs registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid     <= 1'b0;
         o_busy      <= 1'b0;
         o_check_ena <= 1'b0;
         o_done      <= 1'b0;
      end else if (i_soft_rst) begin
         o_valid     <= 1'b0;
         o_busy      <= 1'b0;
         o_check_ena <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         o_valid     <= valid_d;
         o_busy      <= busy_d;
         o_check_ena <= busy_d;
         o_done      <= done_d;
      end
   end

endmodule

// File: tb/tb_tlk2711_tx_pattern_ctrl.sv
// Directed self-checking bench for tlk2711_tx_pattern_ctrl.
module tb_tlk2711_tx_pattern_ctrl;

   logic        clk;
   logic        rst_n;
   logic        i_soft_rst;
   logic        i_tx_start;
   logic [2:0]  i_tx_mode;
   logic [15:0] i_frame_num;
   logic [15:0] i_gap_cycles;
   logic        i_stop;
   logic        i_ready;
   logic        o_valid;
   logic [15:0] o_data;
   logic        o_last;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_frame_cnt;
   logic        o_check_ena;

   int n_checks = 0;
   int n_errors = 0;

   // Results of the last collect() call.
   int r_frames, r_bad_words, r_bad_gap, r_bad_stall, r_bad_misc;
   int r_done, r_extra, r_wrap, r_valid_cycles, r_timeout;

   tlk2711_tx_pattern_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_soft_rst   (i_soft_rst),
      .i_tx_start   (i_tx_start),
      .i_tx_mode    (i_tx_mode),
      .i_frame_num  (i_frame_num),
      .i_gap_cycles (i_gap_cycles),
      .i_stop       (i_stop),
      .i_ready      (i_ready),
      .o_valid      (o_valid),
      .o_data       (o_data),
      .o_last       (o_last),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_frame_cnt  (o_frame_cnt),
      .o_check_ena  (o_check_ena)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference word for data index w (w < last).
   function automatic logic [15:0] pat(input int w);
      logic [7:0] b;
      if (w == 0) return 16'h0001;
      b = 8'(1 + 2 * w);
      return {b, b};
   endfunction

   task automatic pulse_start();
      @(negedge clk) i_tx_start = 1'b1;
      @(negedge clk) i_tx_start = 1'b0;
   endtask

   // Observe one run until o_done (bounded), then post_cycles more idle cycles.
   task automatic collect(input int last, input int gap, input bit stall,
                          input int pulse_frame, input int stop_frame,
                          input bit busy_test, input int post_cycles, input int max_cycles);
      int          wm, fm, cyc, gap_len;
      bit          in_gap, prev_stall, done_seen;
      logic [15:0] prev_data, last_acc, exp;
      logic        prev_last;
      wm = 0; fm = 0; cyc = 0; gap_len = 0;
      in_gap = 0; prev_stall = 0; done_seen = 0;
      prev_data = '0; prev_last = 1'b0; last_acc = '0;
      r_frames = 0; r_bad_words = 0; r_bad_gap = 0; r_bad_stall = 0; r_bad_misc = 0;
      r_done = 0; r_extra = 0; r_wrap = 0; r_valid_cycles = 0; r_timeout = 0;
      while (!done_seen && cyc < max_cycles) begin
         @(negedge clk);
         cyc++;
         i_ready = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
         if (busy_test) begin
            if (cyc == 200) i_tx_mode  = 3'd3;
            if (cyc == 300) i_tx_start = 1'b0;
            if (cyc == 302) i_tx_start = 1'b1;
         end
         if (fm == pulse_frame && wm == 100) i_stop = 1'b1;
         if (fm == pulse_frame && wm == 150) i_stop = 1'b0;
         if (fm == stop_frame  && wm == 200) i_stop = 1'b1;
         if (o_done) begin
            done_seen = 1;
            r_done++;
         end
         if (o_valid) begin
            r_valid_cycles++;
            if (!o_busy || !o_check_ena) r_bad_misc++;
            if (prev_stall && (o_data !== prev_data || o_last !== prev_last)) r_bad_stall++;
            if (in_gap) begin
               if (gap_len != gap) r_bad_gap++;
               in_gap = 0;
            end
            exp = (wm == last) ? 16'(fm) : pat(wm);
            if (o_data !== exp || o_last !== (wm == last)) r_bad_words++;
            if (i_ready) begin
               if (last_acc == 16'hFFFF && o_data == 16'h0101) r_wrap++;
               last_acc = o_data;
               if (wm == last) begin
                  wm = 0; fm++; in_gap = 1; gap_len = 0;
               end else begin
                  wm++;
               end
            end
            prev_stall = !i_ready;
            prev_data  = o_data;
            prev_last  = o_last;
         end else begin
            prev_stall = 0;
            if (in_gap) gap_len++;
         end
      end
      r_frames  = fm;
      r_timeout = done_seen ? 0 : 1;
      repeat (post_cycles) begin
         @(negedge clk);
         cyc++;
         if (busy_test && cyc == 1000) i_tx_start = 1'b0;
         if (o_valid || o_busy || o_done) r_extra++;
      end
      i_stop  = 1'b0;
      i_ready = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; i_soft_rst = 1'b0; i_tx_start = 1'b0; i_tx_mode = 3'd0;
      i_frame_num = 16'd0; i_gap_cycles = 16'd0; i_stop = 1'b0; i_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_cnt", 32'(o_frame_cnt), 32'd0);
      chk("rst_ena", 32'(o_check_ena), 32'd0);
      chk("rst_data_last", 32'({o_last, o_data}), 32'd0);
      rst_n = 1'b1;

      // Mode 0, one frame, no gap, no stall; check start latency
      i_tx_mode = 3'd0; i_frame_num = 16'd1; i_gap_cycles = 16'd0;
      @(negedge clk) i_tx_start = 1'b1;
      @(negedge clk);
      chk("t1_busy_edge0", 32'(o_busy), 32'd0);
      i_tx_start = 1'b0;
      @(negedge clk);
      chk("t1_busy_edge1", 32'(o_busy), 32'd1);
      chk("t1_ena_edge1", 32'(o_check_ena), 32'd1);
      chk("t1_valid_edge1", 32'(o_valid), 32'd0);
      collect(434, 0, 0, -1, -1, 0, 20, 2000);
      chk("t1_timeout", 32'(r_timeout), 32'd0);
      chk("t1_frames", 32'(r_frames), 32'd1);
      chk("t1_words", 32'(r_bad_words), 32'd0);
      chk("t1_valid_cycles", 32'(r_valid_cycles), 32'd435);
      chk("t1_done", 32'(r_done), 32'd1);
      chk("t1_misc", 32'(r_bad_misc), 32'd0);
      chk("t1_extra", 32'(r_extra), 32'd0);
      chk("t1_cnt", 32'(o_frame_cnt), 32'd1);

      // Mode 3, two frames, gap 5
      i_tx_mode = 3'd3; i_frame_num = 16'd2; i_gap_cycles = 16'd5;
      pulse_start();
      collect(5375, 5, 0, -1, -1, 0, 20, 12000);
      chk("t2_timeout", 32'(r_timeout), 32'd0);
      chk("t2_frames", 32'(r_frames), 32'd2);
      chk("t2_words", 32'(r_bad_words), 32'd0);
      chk("t2_gap", 32'(r_bad_gap), 32'd0);
      chk("t2_valid_cycles", 32'(r_valid_cycles), 32'd10752);
      chk("t2_wrap_seen", 32'(r_wrap > 0), 32'd1);
      chk("t2_cnt", 32'(o_frame_cnt), 32'd2);

      // Mode 1, three frames, gap 2, random backpressure
      i_tx_mode = 3'd1; i_frame_num = 16'd3; i_gap_cycles = 16'd2;
      pulse_start();
      collect(434, 2, 1, -1, -1, 0, 20, 6000);
      chk("t3_timeout", 32'(r_timeout), 32'd0);
      chk("t3_frames", 32'(r_frames), 32'd3);
      chk("t3_words", 32'(r_bad_words), 32'd0);
      chk("t3_stall", 32'(r_bad_stall), 32'd0);
      chk("t3_gap", 32'(r_bad_gap), 32'd0);
      chk("t3_cnt", 32'(o_frame_cnt), 32'd3);

      // Continuous run; stop pulse in frame 1 ignored, stop in frame 2 ends run
      i_tx_mode = 3'd0; i_frame_num = 16'd0; i_gap_cycles = 16'd0;
      pulse_start();
      collect(434, 0, 0, 0, 1, 0, 30, 3000);
      chk("t4_timeout", 32'(r_timeout), 32'd0);
      chk("t4_frames", 32'(r_frames), 32'd2);
      chk("t4_words", 32'(r_bad_words), 32'd0);
      chk("t4_gap", 32'(r_bad_gap), 32'd0);
      chk("t4_extra", 32'(r_extra), 32'd0);
      chk("t4_done", 32'(r_done), 32'd1);
      chk("t4_cnt", 32'(o_frame_cnt), 32'd2);

      // Soft reset mid-frame: takes effect at the next edge
      i_frame_num = 16'd0;
      pulse_start();
      repeat (600) @(negedge clk);
      chk("t5_pre_valid", 32'(o_valid), 32'd1);
      chk("t5_pre_cnt", 32'(o_frame_cnt), 32'd1);
      i_soft_rst = 1'b1;
      #1;
      chk("t5_before_edge", 32'(o_valid), 32'd1);
      @(negedge clk);
      chk("t5_valid", 32'(o_valid), 32'd0);
      chk("t5_busy_ena", 32'({o_busy, o_check_ena}), 32'd0);
      chk("t5_cnt", 32'(o_frame_cnt), 32'd0);
      chk("t5_data_last", 32'({o_last, o_data}), 32'd0);
      i_soft_rst = 1'b0;
      i_frame_num = 16'd1;
      pulse_start();
      collect(434, 0, 0, -1, -1, 0, 10, 2000);
      chk("t5_new_frames", 32'(r_frames), 32'd1);
      chk("t5_new_words", 32'(r_bad_words), 32'd0);

      // Asynchronous reset mid-frame: takes effect immediately
      i_frame_num = 16'd0;
      pulse_start();
      repeat (600) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_valid", 32'(o_valid), 32'd0);
      chk("t6_busy", 32'(o_busy), 32'd0);
      chk("t6_cnt", 32'(o_frame_cnt), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      i_frame_num = 16'd1;
      pulse_start();
      collect(434, 0, 0, -1, -1, 0, 10, 2000);
      chk("t6_new_frames", 32'(r_frames), 32'd1);
      chk("t6_new_words", 32'(r_bad_words), 32'd0);

      // Start held high ~1000 cycles, re-edge while busy, mode change mid-run
      i_tx_mode = 3'd0; i_frame_num = 16'd2; i_gap_cycles = 16'd3;
      @(negedge clk) i_tx_start = 1'b1;
      collect(434, 3, 0, -1, -1, 1, 200, 3000);
      i_tx_start = 1'b0;
      chk("t7_timeout", 32'(r_timeout), 32'd0);
      chk("t7_frames", 32'(r_frames), 32'd2);
      chk("t7_words", 32'(r_bad_words), 32'd0);
      chk("t7_gap", 32'(r_bad_gap), 32'd0);
      chk("t7_done", 32'(r_done), 32'd1);
      chk("t7_extra", 32'(r_extra), 32'd0);
      chk("t7_cnt", 32'(o_frame_cnt), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
